// File: rtl/hps_reset_pkg.sv
// Shared definitions for the HPS reset request generators (warm and cold instances).
package hps_reset_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHold    = 3'd1,
        StWaitAck = 3'd2,
        StRelease = 3'd3,
        StCool    = 3'd4
    } state_e;

    localparam int unsigned DefMinHold           = 6;
    localparam int unsigned DefAckTimeout        = 1024;
    localparam int unsigned DefCooldown          = 16;
    localparam bit          DefIgnoreReqWhileBusy = 1'b1;
    localparam int unsigned DefCntW              = 11;

endpackage

// File: rtl/hps_reset_req_cnt.sv
// Clearable up-counter with a terminal compare against a runtime limit; saturates at limit-1.
module hps_reset_req_cnt #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    assign done = (cnt_q == limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (!done) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hps_reset_req_gen.sv
// Turns a one-cycle reset request pulse into a held, acknowledged level toward the HPS
// reset manager, followed by a cooldown guard interval.
module hps_reset_req_gen
    import hps_reset_pkg::*;
#(
    parameter int unsigned MIN_HOLD              = DefMinHold,
    parameter int unsigned ACK_TIMEOUT           = DefAckTimeout,
    parameter int unsigned COOLDOWN              = DefCooldown,
    parameter bit          IGNORE_REQ_WHILE_BUSY = DefIgnoreReqWhileBusy,
    parameter int unsigned CNT_W                 = DefCntW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    input  logic ack_in,
    output logic req_out,
    output logic busy,
    output logic timeout_err
);

    localparam logic [CNT_W-1:0] HoldLim = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] AckLim  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CoolLim = CNT_W'(COOLDOWN);

    state_e           state_q;
    logic             pending_q;
    logic [CNT_W-1:0] limit;
    logic             cnt_clr;
    logic             cnt_done;

    always_comb begin
        limit = CoolLim;
        case (state_q)
            StHold:               limit = HoldLim;
            StWaitAck, StRelease: limit = AckLim;
            default:              limit = CoolLim;
        endcase
    end

    // Counter must clear exactly when the FSM below leaves its current state.
    always_comb begin
        cnt_clr = 1'b1;
        case (state_q)
            StIdle:    cnt_clr = 1'b1;
            StHold:    cnt_clr = cnt_done;
            StWaitAck: cnt_clr = ack_in | cnt_done;
            StRelease: cnt_clr = ~ack_in | cnt_done;
            StCool:    cnt_clr = cnt_done;
            default:   cnt_clr = 1'b1;
        endcase
    end

    hps_reset_req_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .limit (limit),
        .done  (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            req_out     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (!IGNORE_REQ_WHILE_BUSY && pulse_in && state_q != StIdle) begin
                pending_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pulse_in) begin
                        state_q     <= StHold;
                        req_out     <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                StHold: begin
                    if (cnt_done) begin
                        state_q <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (ack_in) begin
                        state_q <= StRelease;
                        req_out <= 1'b0;
                    end else if (cnt_done) begin
                        state_q     <= StCool;
                        req_out     <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                StRelease: begin
                    if (!ack_in) begin
                        state_q <= StCool;
                    end else if (cnt_done) begin
                        state_q     <= StCool;
                        timeout_err <= 1'b1;
                    end
                end
                StCool: begin
                    if (cnt_done) begin
                        // A pulse coinciding with the exit restarts directly so it is not lost;
                        // with a pending request it stays latched for the next round.
                        if (pending_q || pulse_in) begin
                            state_q     <= StHold;
                            req_out     <= 1'b1;
                            timeout_err <= 1'b0;
                            pending_q   <= pending_q && pulse_in && !IGNORE_REQ_WHILE_BUSY;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
